// File: rtl/pcie_hcmd_slot_defs.sv
// Shared host-command slot definitions: slot geometry and free-request source IDs.
// The slot manager imports the same package.
package pcie_hcmd_slot_defs;

   localparam int unsigned P_SLOT_WIDTH      = 1024;
   localparam int unsigned P_SLOT_TAG_WIDTH  = 10;
   localparam int unsigned P_FIFO_DEPTH_LOG2 = 3;

   typedef enum logic {
      SRC_CPL = 1'b0,
      SRC_ABT = 1'b1
   } slot_src_e;

   function automatic slot_src_e other_src(input slot_src_e src);
      return (src == SRC_CPL) ? SRC_ABT : SRC_CPL;
   endfunction

endpackage

// File: rtl/pcie_hcmd_tag_fifo.sv
// Synchronous tag FIFO, depth 2**P_DEPTH_LOG2, first-word-fall-through read port.
// Pushes while full and pops while empty are ignored.
module pcie_hcmd_tag_fifo
   import pcie_hcmd_slot_defs::*;
#(
   parameter int unsigned P_DATA_WIDTH = P_SLOT_TAG_WIDTH,
   parameter int unsigned P_DEPTH_LOG2 = P_FIFO_DEPTH_LOG2
) (
   input  logic                    pcie_user_clk,
   input  logic                    pcie_user_rst_n,
   input  logic                    push,
   input  logic [P_DATA_WIDTH-1:0] push_data,
   input  logic                    pop,
   output logic [P_DATA_WIDTH-1:0] pop_data,
   output logic                    full,
   output logic                    empty
);

   localparam int unsigned DEPTH = 2 ** P_DEPTH_LOG2;

   logic [P_DATA_WIDTH-1:0] mem [DEPTH];
   logic [P_DEPTH_LOG2:0]   wr_ptr;
   logic [P_DEPTH_LOG2:0]   rd_ptr;
   logic                    push_ok;
   logic                    pop_ok;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign full  = (wr_ptr[P_DEPTH_LOG2] != rd_ptr[P_DEPTH_LOG2]) &&
                  (wr_ptr[P_DEPTH_LOG2-1:0] == rd_ptr[P_DEPTH_LOG2-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;
   assign pop_data = mem[rd_ptr[P_DEPTH_LOG2-1:0]];

   always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
      if (!pcie_user_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + {{P_DEPTH_LOG2{1'b0}}, 1'b1};
         if (pop_ok)  rd_ptr <= rd_ptr + {{P_DEPTH_LOG2{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge pcie_user_clk) begin
      if (push_ok) mem[wr_ptr[P_DEPTH_LOG2-1:0]] <= push_data;
   end

endmodule

// File: rtl/pcie_hcmd_slot_free_arb.sv
// Merges completion and abort slot-free requests into one registered free pulse per cycle.
// Optional allocated-tag duplicate check: define SLOT_FREE_DUP_CHECK_EN.
module pcie_hcmd_slot_free_arb
   import pcie_hcmd_slot_defs::*;
#(
   parameter int unsigned P_SLOT_WIDTH      = pcie_hcmd_slot_defs::P_SLOT_WIDTH,
   parameter int unsigned P_SLOT_TAG_WIDTH  = pcie_hcmd_slot_defs::P_SLOT_TAG_WIDTH,
   parameter int unsigned P_FIFO_DEPTH_LOG2 = pcie_hcmd_slot_defs::P_FIFO_DEPTH_LOG2
) (
   input  logic                        pcie_user_clk,
   input  logic                        pcie_user_rst_n,
   input  logic                        cpl_free_valid,
   output logic                        cpl_free_ready,
   input  logic [P_SLOT_TAG_WIDTH-1:0] cpl_free_tag,
   input  logic                        abt_free_valid,
   output logic                        abt_free_ready,
   input  logic [P_SLOT_TAG_WIDTH-1:0] abt_free_tag,
   input  logic                        hcmd_slot_rdy,
   input  logic                        hcmd_slot_alloc_en,
   input  logic [P_SLOT_TAG_WIDTH-1:0] hcmd_slot_tag,
   output logic                        hcmd_slot_free_en,
   output logic [P_SLOT_TAG_WIDTH-1:0] hcmd_slot_invalid_tag,
   output logic                        free_err,
   output logic [P_SLOT_TAG_WIDTH-1:0] free_err_tag
);

   if (P_SLOT_WIDTH < (32'd1 << P_SLOT_TAG_WIDTH)) begin : g_width_check
      $error("P_SLOT_WIDTH cannot hold every P_SLOT_TAG_WIDTH tag");
   end

   logic                        cpl_full, cpl_empty, abt_full, abt_empty;
   logic [P_SLOT_TAG_WIDTH-1:0] cpl_head, abt_head;
   logic                        grant_cpl, grant_abt, pop_any;
   logic [P_SLOT_TAG_WIDTH-1:0] pop_tag;
   logic                        issue_free;
   slot_src_e                   rr_ptr;

   assign cpl_free_ready = ~cpl_full;
   assign abt_free_ready = ~abt_full;

   pcie_hcmd_tag_fifo #(
      .P_DATA_WIDTH (P_SLOT_TAG_WIDTH),
      .P_DEPTH_LOG2 (P_FIFO_DEPTH_LOG2)
   ) u_cpl_fifo (
      .pcie_user_clk   (pcie_user_clk),
      .pcie_user_rst_n (pcie_user_rst_n),
      .push            (cpl_free_valid),
      .push_data       (cpl_free_tag),
      .pop             (grant_cpl),
      .pop_data        (cpl_head),
      .full            (cpl_full),
      .empty           (cpl_empty)
   );

   pcie_hcmd_tag_fifo #(
      .P_DATA_WIDTH (P_SLOT_TAG_WIDTH),
      .P_DEPTH_LOG2 (P_FIFO_DEPTH_LOG2)
   ) u_abt_fifo (
      .pcie_user_clk   (pcie_user_clk),
      .pcie_user_rst_n (pcie_user_rst_n),
      .push            (abt_free_valid),
      .push_data       (abt_free_tag),
      .pop             (grant_abt),
      .pop_data        (abt_head),
      .full            (abt_full),
      .empty           (abt_empty)
   );

   // The RR pointer only breaks ties; a lone non-empty FIFO always wins.
   always_comb begin
      grant_cpl = ~cpl_empty & (abt_empty | (rr_ptr == SRC_CPL));
      grant_abt = ~abt_empty & (cpl_empty | (rr_ptr == SRC_ABT));
      pop_any   = grant_cpl | grant_abt;
      pop_tag   = grant_abt ? abt_head : cpl_head;
   end

   always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
      if (!pcie_user_rst_n) begin
         rr_ptr <= SRC_CPL;
      end else if (!cpl_empty && !abt_empty) begin
         rr_ptr <= other_src(rr_ptr);
      end
   end

`ifdef SLOT_FREE_DUP_CHECK_EN
   logic [P_SLOT_WIDTH-1:0] slot_bitmap;
   logic                    tag_allocated;
   logic                    issue_err;

   assign tag_allocated = slot_bitmap[pop_tag];
   assign issue_free    = pop_any & tag_allocated;
   assign issue_err     = pop_any & ~tag_allocated;

   // Set after clear so a same-cycle alloc of the popped tag leaves the bit set.
   always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
      if (!pcie_user_rst_n) begin
         slot_bitmap <= '0;
      end else begin
         if (issue_free) slot_bitmap[pop_tag] <= 1'b0;
         if (hcmd_slot_rdy && hcmd_slot_alloc_en) slot_bitmap[hcmd_slot_tag] <= 1'b1;
      end
   end

   always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
      if (!pcie_user_rst_n) begin
         free_err     <= 1'b0;
         free_err_tag <= '0;
      end else begin
         free_err <= issue_err;
         if (issue_err) free_err_tag <= pop_tag;
      end
   end
`else
   logic unused_snoop;

   assign unused_snoop = ^{hcmd_slot_rdy, hcmd_slot_alloc_en, hcmd_slot_tag};
   assign issue_free   = pop_any;
   assign free_err     = 1'b0;
   assign free_err_tag = '0;
`endif

   always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
      if (!pcie_user_rst_n) begin
         hcmd_slot_free_en     <= 1'b0;
         hcmd_slot_invalid_tag <= '0;
      end else begin
         hcmd_slot_free_en <= issue_free;
         if (issue_free) hcmd_slot_invalid_tag <= pop_tag;
      end
   end

endmodule
